// File: rtl/s2p_lanes_param_if.sv
// Serial-in / parallel-out bundle for the multi-lane deserializer.
// Latency: none; this is wiring only.
// Backpressure: none; the sink must accept each one-cycle valid pulse.
interface s2p_lanes_param_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic                   enb;
  logic [LANES-1:0]       s_in;
  logic [1:0]             modo;
  logic                   dir;
  logic [LANES*WIDTH-1:0] p_out;
  logic                   valid;
  logic                   aligned;

  modport master (
    output enb, s_in, modo, dir,
    input  p_out, valid, aligned
  );

  modport slave (
    input  enb, s_in, modo, dir,
    output p_out, valid, aligned
  );
endinterface

// File: rtl/s2p_lanes_param.sv
// Multi-lane serial-to-parallel deserializer with optional comma alignment on lane 0.
// Latency: p_out/valid update on the edge that samples a word's last bit.
// Backpressure: none; enb=0 or a hold mode freezes all state without losing bits.
module s2p_lanes_param #(
  parameter int               LANES = 4,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(8'hBC)
) (
  input  logic               clk,
  input  logic               rst,
  s2p_lanes_param_if.slave   bus
);

  localparam int             CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   aligned_q, aligned_d;
  logic                   valid_q;
  logic                   load;
  logic                   shift;
  logic                   cnt_wrap;
  logic [WIDTH-1:0]       sr  [LANES];
  logic [WIDTH-1:0]       nsr [LANES];
  logic [LANES*WIDTH-1:0] nsr_flat;
  logic [LANES*WIDTH-1:0] p_out_q;

  assign shift    = bus.enb && (bus.modo == 2'b01 || bus.modo == 2'b10);
  assign cnt_wrap = (cnt_q == CNT_MAX);
  assign cnt_inc  = cnt_wrap ? '0 : cnt_q + CW'(1);

  // Next value of every lane register, including the bit sampled this edge.
  always_comb begin
    nsr_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.dir)
        nsr[i] = {bus.s_in[i], sr[i][WIDTH-1:1]};
      else
        nsr[i] = {sr[i][WIDTH-2:0], bus.s_in[i]};
      nsr_flat[i*WIDTH +: WIDTH] = nsr[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aligned_d = aligned_q;
    load      = 1'b0;
    if (bus.enb) begin
      case (bus.modo)
        2'b01: begin
          // Free-run drops any lock but keeps the word phase.
          state_d   = HUNT;
          aligned_d = 1'b0;
          cnt_d     = cnt_inc;
          load      = cnt_wrap;
        end
        2'b10: begin
          if (state_q == HUNT) begin
            cnt_d = '0;
            if (nsr[0] == COMMA) begin
              state_d   = LOCKED;
              aligned_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            load  = cnt_wrap;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      aligned_q <= 1'b0;
      valid_q   <= 1'b0;
      p_out_q   <= '0;
      for (int i = 0; i < LANES; i++)
        sr[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aligned_q <= aligned_d;
      valid_q   <= load;
      if (shift) begin
        for (int i = 0; i < LANES; i++)
          sr[i] <= nsr[i];
      end
      if (load)
        p_out_q <= nsr_flat;
    end
  end

  assign bus.p_out   = p_out_q;
  assign bus.valid   = valid_q;
  assign bus.aligned = aligned_q;

endmodule

// File: tb/tb_s2p_lanes_param.sv
// Directed bench for s2p_lanes_param: free-run both directions, stalls, comma lock,
// lock loss and asynchronous reset mid-word, with hand-computed expectations.
module tb_s2p_lanes_param;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  s2p_lanes_param_if #(.LANES(4), .WIDTH(8)) bus ();

  s2p_lanes_param #(.LANES(4), .WIDTH(8), .COMMA(8'hBC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends bits k0..k1-1 of each lane byte of w; valid is expected only after bit 7.
  task automatic send_bits(input logic [31:0] w, input bit lsb, input int k0, input int k1,
                           input string tag);
    logic [3:0] v;
    for (int k = k0; k < k1; k++) begin
      for (int l = 0; l < 4; l++)
        v[l] = lsb ? w[l*8 + k] : w[l*8 + 7 - k];
      bus.s_in = v;
      step();
      chk($sformatf("%s_valid_b%0d", tag, k), {31'b0, bus.valid}, {31'b0, (k == 7)});
    end
  endtask

  initial begin
    logic [10:0] junk_comma;
    logic [7:0]  comma;
    total = 0;
    bad   = 0;
    rst      = 1'b1;
    bus.enb  = 1'b0;
    bus.modo = 2'b00;
    bus.dir  = 1'b0;
    bus.s_in = 4'h0;
    #12;
    chk("rst_p_out",   bus.p_out, 32'h0);
    chk("rst_valid",   {31'b0, bus.valid}, 32'h0);
    chk("rst_aligned", {31'b0, bus.aligned}, 32'h0);
    rst      = 1'b0;
    bus.enb  = 1'b1;
    bus.modo = 2'b01;

    // Free-run, MSB-first
    send_bits(32'hA53CF00F, 1'b0, 0, 8, "t1");
    chk("t1_p_out",   bus.p_out, 32'hA53CF00F);
    chk("t1_aligned", {31'b0, bus.aligned}, 32'h0);

    // Free-run, LSB-first
    bus.dir = 1'b1;
    send_bits(32'hA53CF00F, 1'b1, 0, 8, "t2");
    chk("t2_p_out", bus.p_out, 32'hA53CF00F);
    bus.dir = 1'b0;

    // Stall with enb=0, garbage on the lines must not be sampled
    send_bits(32'h12345678, 1'b0, 0, 4, "t4a");
    bus.enb  = 1'b0;
    bus.s_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4a_stall_valid", {31'b0, bus.valid}, 32'h0);
      chk("t4a_stall_hold",  bus.p_out, 32'hA53CF00F);
    end
    bus.enb = 1'b1;
    send_bits(32'h12345678, 1'b0, 4, 8, "t4a");
    chk("t4a_p_out", bus.p_out, 32'h12345678);

    // Stall with reserved mode 11
    send_bits(32'h9ABCDEF0, 1'b0, 0, 4, "t4b");
    bus.modo = 2'b11;
    bus.s_in = 4'h5;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4b_stall_valid", {31'b0, bus.valid}, 32'h0);
    end
    bus.modo = 2'b01;
    send_bits(32'h9ABCDEF0, 1'b0, 4, 8, "t4b");
    chk("t4b_p_out", bus.p_out, 32'h9ABCDEF0);

    // Comma alignment: junk 101, then BC on lane 0, then data
    bus.modo   = 2'b10;
    junk_comma = 11'b101_10111100;
    for (int k = 0; k < 11; k++) begin
      bus.s_in = {3'b000, junk_comma[10-k]};
      step();
      chk($sformatf("t3_hunt_valid_%0d", k), {31'b0, bus.valid}, 32'h0);
      chk($sformatf("t3_hunt_aligned_%0d", k), {31'b0, bus.aligned}, {31'b0, (k == 10)});
    end
    send_bits(32'h1122335A, 1'b0, 0, 8, "t3");
    chk("t3_p_out",   bus.p_out, 32'h1122335A);
    chk("t3_lane0",   {24'b0, bus.p_out[7:0]}, 32'h5A);
    chk("t3_aligned", {31'b0, bus.aligned}, 32'h1);

    // Lock loss via one free-run cycle, then re-hunt
    bus.modo = 2'b01;
    bus.s_in = 4'h0;
    step();
    chk("t6_drop_aligned", {31'b0, bus.aligned}, 32'h0);
    bus.modo = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t6_hunt_valid",   {31'b0, bus.valid}, 32'h0);
      chk("t6_hunt_aligned", {31'b0, bus.aligned}, 32'h0);
    end
    comma = 8'hBC;
    for (int k = 0; k < 8; k++) begin
      bus.s_in = {3'b000, comma[7-k]};
      step();
      chk("t6_relock_valid",   {31'b0, bus.valid}, 32'h0);
      chk("t6_relock_aligned", {31'b0, bus.aligned}, {31'b0, (k == 7)});
    end
    // A comma seen while locked is plain data
    send_bits(32'h445566BC, 1'b0, 0, 8, "t6");
    chk("t6_p_out",   bus.p_out, 32'h445566BC);
    chk("t6_aligned", {31'b0, bus.aligned}, 32'h1);

    // Asynchronous reset between edges, mid-word, while locked
    send_bits(32'hDEADBEEF, 1'b0, 0, 5, "t5_pre");
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_p_out",   bus.p_out, 32'h0);
    chk("t5_rst_valid",   {31'b0, bus.valid}, 32'h0);
    chk("t5_rst_aligned", {31'b0, bus.aligned}, 32'h0);
    #2;
    rst      = 1'b0;
    bus.modo = 2'b01;
    send_bits(32'h0F1E2D3C, 1'b0, 0, 8, "t5");
    chk("t5_p_out", bus.p_out, 32'h0F1E2D3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2p_lanes_param.md
# s2p_lanes_param

Parametrised multi-lane serial-to-parallel deserializer. It is the single-clock successor of the four-lane, two-clock s2p path. Each of LANES serial inputs shifts into a WIDTH-bit register, and a word counter replaces the slow capture clock with a one-cycle VALID strobe. An optional comma-alignment mode hunts for a framing pattern on lane 0 before delivering words, and reports lock on ALIGNED.

## Interface
- LANES, default 4: number of serial lanes.
- WIDTH, default 8: bits per lane word; must be ≥2.
- COMMA, default 8'hBC (WIDTH bits): alignment pattern searched on lane 0.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RESET  input  1  reset, asynchronous, active-high.
- ENB  input  1  enable; 0 freezes all state.
- S_IN  input  LANES  serial bit per lane, sampled on the rising edge of CLK.
- MODO  input  2  operating mode:
  - 00: hold.
  - 01: free-run.
  - 10: comma-aligned.
  - 11: reserved, behaves as hold.
- DIR  input  1  shift direction:
  - 0: MSB-first; the new bit enters the LSB and the register shifts left.
  - 1: LSB-first; the new bit enters the MSB and the register shifts right.
- P_OUT  output  LANES*WIDTH  last completed word; lane i occupies P_OUT[i*WIDTH +: WIDTH].
- VALID  output  1  high for exactly one cycle after each word load.
- ALIGNED  output  1  comma lock status; meaningful in MODO=10.

## Operation
- Shift registers SR[i], i = 0..LANES-1, each WIDTH bits. There is one shared bit counter CNT, $clog2(WIDTH) bits wide, that counts 0..WIDTH-1 and wraps.
- A "shift cycle" is any edge with ENB=1 and MODO in {01, 10}. Every SR shifts only on shift cycles; otherwise SR, CNT, P_OUT, the FSM and ALIGNED all hold.
- nSR[i] is the value SR[i] takes on the current edge (the incoming bit included).
- FSM state HUNT:
  - Active only in MODO=10.
  - CNT is held at 0 and VALID stays 0.
  - When nSR[0] == COMMA: go to LOCKED, set ALIGNED=1, CNT stays 0. The comma word itself is not delivered.
- FSM state LOCKED (MODO=10), and free-run (MODO=01, FSM forced to HUNT, ALIGNED=0):
  - Each shift cycle: CNT ← CNT+1.
  - When CNT == WIDTH-1: P_OUT ← concatenation of nSR, VALID ← 1, CNT ← 0.
  - A COMMA value received in LOCKED is delivered as ordinary data; the lock is not re-evaluated.
- Mode changes:
  - Any MODO=01 cycle with ENB=1 clears lock: state to HUNT, ALIGNED ← 0. CNT continues from its current value.
  - Entering MODO=10 from 01 starts in HUNT with CNT ← 0.
  - Hold (MODO 00/11 or ENB=0) preserves the LOCKED state.
- DIR may change only between words. A mid-word change corrupts the current word only; no other state is affected.

## Timing
- Reset (asynchronous, immediate while RESET=1):
  - SR = 0, CNT = 0, P_OUT = 0.
  - VALID = 0, ALIGNED = 0, FSM = HUNT.
- After reset release, the first word completes on the WIDTH-th shift cycle.
- Latency: the edge that samples a word's last bit also loads P_OUT and raises VALID, so data is visible in the following cycle. VALID drops on the next edge unless another word completes; this is possible only if WIDTH=1, which is disallowed.
- Word rate: VALID pulses every WIDTH shift cycles. Hold cycles stretch the interval one-for-one without losing bits.
- ALIGNED rises on the same edge that matches the comma. The first VALID after lock comes exactly WIDTH shift cycles later.
- RESET during a word discards the partial word. P_OUT returns to 0, and a VALID due on that edge is suppressed.
- P_OUT holds its last value between VALID pulses and across hold periods.

## Test plan
1. Free-run, MSB-first:
   - Setup: LANES=4, WIDTH=8, MODO=01, DIR=0, ENB=1.
   - Stimulus: lane3=A5, lane2=3C, lane1=F0, lane0=0F, MSB-first, from reset.
   - Expected: VALID on the 8th edge only; P_OUT=32'hA53CF00F; ALIGNED=0.
2. Free-run, LSB-first: same bytes sent LSB-first with DIR=1 -> identical P_OUT=32'hA53CF00F and VALID timing.
3. Comma alignment:
   - Stimulus: MODO=10, DIR=0; lane0 sends 3 junk bits 101, then BC, then 5A.
   - Expected: ALIGNED rises on the edge the BC's last bit is sampled.
   - Expected: no VALID during the junk bits or the comma.
   - Expected: VALID exactly 8 edges later, with P_OUT[7:0]=5A.
4. Stall:
   - Stimulus: in free-run, hold ENB=0 for 3 cycles after bit 4 of a word.
   - Expected: VALID delayed by exactly 3 cycles; P_OUT equals the unstalled result.
   - Stimulus: MODO=11 for 2 cycles.
   - Expected: same behaviour as ENB=0.
5. Reset mid-word:
   - Stimulus: assert RESET asynchronously after 5 bits, between edges.
   - Expected: P_OUT=0, VALID=0, ALIGNED=0 immediately.
   - Expected: after release, the next VALID follows 8 new shift cycles.
6. Lock loss:
   - Stimulus: while LOCKED, switch to MODO=01 for one cycle.
   - Expected: ALIGNED=0 on that edge.
   - Stimulus: return to MODO=10.
   - Expected: no VALID until a new BC match.
